// File: rtl/core_bus_unit.sv
// core_bus_unit: arbitrates instruction fetch and data access requests onto a
// single request/acknowledge bus. One transaction at a time; data access wins
// over fetch when both are requested in the same idle cycle.
//
// Ports
//   clk_in, reset_in              clock, async active-low reset
//   if_ce_in/if_addr_in           fetch request from pc stage
//   if_flush_in                   jump flush (drops the in-flight fetch result)
//   if_rdata_out/if_valid_out     registered instruction + one-cycle valid pulse
//   if_stallreq_out               fetch stall request (combinational)
//   mem_ce_in/we/addr/wdata/be    data access request
//   mem_rdata_out/mem_valid_out   registered read data + one-cycle valid pulse
//   mem_stallreq_out              data stall request (combinational)
//   bus_req/we/addr/wdata/be_out  registered bus request, held until ack
//   bus_ack_in/bus_rdata_in       bus response
//   bus_err_out                   sticky timeout error
//
// Build option: define BUS_TIMEOUT_EN to enable the wait-state watchdog;
// otherwise wait states persist until ack and bus_err_out is tied low.
module core_bus_unit #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    if_ce_in,
  input  logic [ADDR_WIDTH-1:0]   if_addr_in,
  input  logic                    if_flush_in,
  output logic [DATA_WIDTH-1:0]   if_rdata_out,
  output logic                    if_valid_out,
  output logic                    if_stallreq_out,
  input  logic                    mem_ce_in,
  input  logic                    mem_we_in,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_in,
  input  logic [DATA_WIDTH-1:0]   mem_wdata_in,
  input  logic [DATA_WIDTH/8-1:0] mem_be_in,
  output logic [DATA_WIDTH-1:0]   mem_rdata_out,
  output logic                    mem_valid_out,
  output logic                    mem_stallreq_out,
  output logic                    bus_req_out,
  output logic                    bus_we_out,
  output logic [ADDR_WIDTH-1:0]   bus_addr_out,
  output logic [DATA_WIDTH-1:0]   bus_wdata_out,
  output logic [DATA_WIDTH/8-1:0] bus_be_out,
  input  logic                    bus_ack_in,
  input  logic [DATA_WIDTH-1:0]   bus_rdata_in,
  output logic                    bus_err_out
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = 8;

  // Elaboration-time parameter sanity checks
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("core_bus_unit: TIMEOUT_CYCLES must be in 2..255");
  end
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_width
    $error("core_bus_unit: DATA_WIDTH must be a non-zero multiple of 8");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  req_d, we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [BE_W-1:0]       be_d;
  logic [DATA_WIDTH-1:0] if_rdata_d, mem_rdata_d;
  logic                  if_valid_d, mem_valid_d;
  logic                  flush_q, flush_d;
  logic                  mem_go, if_go, timeout, drop_fetch;

  // Stall while a port is requesting and its result is not being delivered
  assign if_stallreq_out  = if_ce_in  & ~if_valid_out;
  assign mem_stallreq_out = mem_ce_in & ~mem_valid_out;

  // A port may not relaunch in the cycle its own valid pulse is high
  assign mem_go     = mem_ce_in & ~mem_valid_out;
  assign if_go      = if_ce_in & ~if_valid_out & ~if_flush_in;
  // A flush seen anytime during the fetch wait (including the ack cycle) drops it
  assign drop_fetch = flush_q | if_flush_in;

`ifdef BUS_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_d;

  assign timeout = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts wait cycles, restarts on every return to idle
  always_comb begin
    cnt_d = '0;
    err_d = bus_err_out;
    if (state_q != IDLE && !bus_ack_in) begin
      if (timeout) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      cnt_q       <= '0;
      bus_err_out <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bus_err_out <= err_d;
    end
  end
`else
  assign timeout     = 1'b0;
  assign bus_err_out = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    req_d       = bus_req_out;
    we_d        = bus_we_out;
    addr_d      = bus_addr_out;
    wdata_d     = bus_wdata_out;
    be_d        = bus_be_out;
    if_rdata_d  = if_rdata_out;
    mem_rdata_d = mem_rdata_out;
    if_valid_d  = 1'b0;
    mem_valid_d = 1'b0;
    flush_d     = flush_q;

    unique case (state_q)
      IDLE: begin
        flush_d = 1'b0;
        if (mem_go) begin
          state_d = MEM_WAIT;
          req_d   = 1'b1;
          we_d    = mem_we_in;
          addr_d  = mem_addr_in;
          wdata_d = mem_wdata_in;
          be_d    = mem_be_in;
        end else if (if_go) begin
          state_d = IF_WAIT;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = if_addr_in;
          wdata_d = '0;
          be_d    = '1;
        end
      end

      IF_WAIT: begin
        if (if_flush_in) flush_d = 1'b1;
        if (bus_ack_in) begin
          state_d = IDLE;
          req_d   = 1'b0;
          flush_d = 1'b0;
          if (!drop_fetch) begin
            if_rdata_d = bus_rdata_in;
            if_valid_d = 1'b1;
          end
        end else if (timeout) begin
          state_d = IDLE;
          req_d   = 1'b0;
          flush_d = 1'b0;
          if (!drop_fetch) begin
            if_rdata_d = '0;
            if_valid_d = 1'b1;
          end
        end
      end

      MEM_WAIT: begin
        if (bus_ack_in) begin
          state_d     = IDLE;
          req_d       = 1'b0;
          mem_valid_d = 1'b1;
          // Writes leave the read-data register untouched
          if (!bus_we_out) mem_rdata_d = bus_rdata_in;
        end else if (timeout) begin
          state_d     = IDLE;
          req_d       = 1'b0;
          mem_valid_d = 1'b1;
          mem_rdata_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        flush_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q       <= IDLE;
      bus_req_out   <= 1'b0;
      bus_we_out    <= 1'b0;
      bus_addr_out  <= '0;
      bus_wdata_out <= '0;
      bus_be_out    <= '0;
      if_rdata_out  <= '0;
      mem_rdata_out <= '0;
      if_valid_out  <= 1'b0;
      mem_valid_out <= 1'b0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus_req_out   <= req_d;
      bus_we_out    <= we_d;
      bus_addr_out  <= addr_d;
      bus_wdata_out <= wdata_d;
      bus_be_out    <= be_d;
      if_rdata_out  <= if_rdata_d;
      mem_rdata_out <= mem_rdata_d;
      if_valid_out  <= if_valid_d;
      mem_valid_out <= mem_valid_d;
      flush_q       <= flush_d;
    end
  end

endmodule
